// File: rtl/kernel_kcore_start_token_reader_if.sv
// rtl/kernel_kcore_start_token_reader_if.sv - start FIFO read port and ap_start/ap_ready/ap_done handshake bundle
interface kernel_kcore_start_token_reader_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  if_empty_n;
    logic                  if_read;
    logic                  if_read_ce;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_done;

    // master: the token reader; slave: the FIFO plus downstream process
    modport master (
        input  if_empty_n, if_dout, ap_ready, ap_done,
        output if_read, if_read_ce, ap_start
    );

    modport slave (
        output if_empty_n, if_dout, ap_ready, ap_done,
        input  if_read, if_read_ce, ap_start
    );
endinterface

// File: rtl/kernel_kcore_start_token_reader.sv
// rtl/kernel_kcore_start_token_reader.sv - pops start tokens, runs the ap_start handshake, counts runs
// Optional one-entry prefetch slot enabled by KCORE_START_TOKEN_PREFETCH_EN.
module kernel_kcore_start_token_reader #(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    kernel_kcore_start_token_reader_if.master    bus,
    output logic [DATA_WIDTH-1:0]                token_data,
    output logic                                 busy,
    output logic [CNT_WIDTH-1:0]                 tokens_served
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] token_next;
    logic                  read_req;
    logic                  cnt_inc;

`ifdef KCORE_START_TOKEN_PREFETCH_EN
    logic                  slot_full;
    logic                  slot_full_next;
    logic [DATA_WIDTH-1:0] slot_data;
    logic [DATA_WIDTH-1:0] slot_data_next;
`endif

    always_comb begin
        state_next = state;
        token_next = token_data;
        read_req   = 1'b0;
        cnt_inc    = 1'b0;
`ifdef KCORE_START_TOKEN_PREFETCH_EN
        slot_full_next = slot_full;
        slot_data_next = slot_data;
`endif
        case (state)
            IDLE: begin
                if (bus.if_empty_n) begin
                    read_req   = 1'b1;
                    token_next = bus.if_dout;
                    state_next = START;
                end
            end
            START: begin
                if (bus.ap_ready) begin
                    if (bus.ap_done) begin
                        cnt_inc    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
`ifdef KCORE_START_TOKEN_PREFETCH_EN
                if (bus.ap_done) begin
                    cnt_inc = 1'b1;
                    if (slot_full) begin
                        token_next     = slot_data;
                        slot_full_next = 1'b0;
                        state_next     = START;
                    end else if (bus.if_empty_n) begin
                        // Slot empty but a token is visible now: forward it straight into the run.
                        read_req   = 1'b1;
                        token_next = bus.if_dout;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!slot_full && bus.if_empty_n) begin
                    read_req       = 1'b1;
                    slot_full_next = 1'b1;
                    slot_data_next = bus.if_dout;
                end
`else
                if (bus.ap_done) begin
                    cnt_inc    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            token_data    <= '0;
            tokens_served <= '0;
        end else begin
            state      <= state_next;
            token_data <= token_next;
            if (cnt_inc && !(&tokens_served)) begin
                tokens_served <= tokens_served + CNT_WIDTH'(1);
            end
        end
    end

`ifdef KCORE_START_TOKEN_PREFETCH_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_full <= 1'b0;
            slot_data <= '0;
        end else begin
            slot_full <= slot_full_next;
            slot_data <= slot_data_next;
        end
    end
`endif

    // Gate with reset so no token is popped while the block is held in reset.
    assign bus.if_read    = read_req & reset_n;
    assign bus.if_read_ce = 1'b1;
    assign bus.ap_start   = (state == START);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_kernel_kcore_start_token_reader.sv
// tb/tb_kernel_kcore_start_token_reader.sv - self-checking bench with FIFO/downstream model
module tb_kernel_kcore_start_token_reader;
    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int CW2 = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    kernel_kcore_start_token_reader_if #(.DATA_WIDTH(DW)) bus ();
    kernel_kcore_start_token_reader_if #(.DATA_WIDTH(DW)) bus2 ();

    logic [DW-1:0]  token_data, token_data2;
    logic           busy, busy2;
    logic [CW-1:0]  cnt;
    logic [CW2-1:0] cnt2;

    kernel_kcore_start_token_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .token_data(token_data), .busy(busy), .tokens_served(cnt)
    );

    kernel_kcore_start_token_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .token_data(token_data2), .busy(busy2), .tokens_served(cnt2)
    );

    assign bus2.if_empty_n = bus.if_empty_n;
    assign bus2.if_dout    = bus.if_dout;
    assign bus2.ap_ready   = bus.ap_ready;
    assign bus2.ap_done    = bus.ap_done;

    int checks = 0;
    int errors = 0;
    int runs   = 0;
    int reads  = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pending[$];

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic push(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        pending.push_back(v);
    endtask

    task automatic drive(input logic rdy, input logic dn);
        bus.if_empty_n = (fifo_q.size() != 0);
        bus.if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
        bus.ap_ready   = rdy;
        bus.ap_done    = dn;
        #1;
    endtask

    task automatic commit();
        logic rd;
        rd = bus.if_read;
        checks++;
        if (rd === 1'b1 && bus.if_empty_n !== 1'b1) begin
            errors++;
            $display("FAIL read_when_empty: if_read=%b if_empty_n=%b, required if_read=0", rd, bus.if_empty_n);
        end
        checks++;
        if (bus2.if_read !== rd || bus2.ap_start !== bus.ap_start) begin
            errors++;
            $display("FAIL width_variant_match: if_read %b/%b ap_start %b/%b, required equal",
                     rd, bus2.if_read, bus.ap_start, bus2.ap_start);
        end
        @(posedge clk);
        if (rd === 1'b1 && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            reads++;
        end
        @(negedge clk);
    endtask

    // Downstream process: waits for ap_start, answers ap_ready after rdy_dly cycles,
    // ap_done done_dly cycles after that (0 = same cycle, negative = never).
    task automatic serve_run(input int rdy_dly, input int done_dly, output int hi_cycles);
        int n;
        logic [DW-1:0] exp_tok;
        hi_cycles = 0;
        n = 0;
        drive(0, 0);
        while (bus.ap_start !== 1'b1 && n < 40) begin
            commit();
            drive(0, 0);
            n++;
        end
        checks++;
        if (bus.ap_start !== 1'b1 || pending.size() == 0) begin
            errors++;
            $display("FAIL start_seen: ap_start=%b pending=%0d, required ap_start=1 with a pending token",
                     bus.ap_start, pending.size());
            return;
        end
        exp_tok = pending.pop_front();
        checks++;
        if (token_data !== exp_tok || token_data2 !== exp_tok) begin
            errors++;
            $display("FAIL token_data: got %h/%h, required %h", token_data, token_data2, exp_tok);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            checks++;
            if (bus.ap_start !== 1'b1) begin
                errors++;
                $display("FAIL ap_start_hold: ap_start=%b before ap_ready, required 1", bus.ap_start);
            end
            hi_cycles++;
            commit();
            drive(0, 0);
        end
        drive(1'b1, done_dly == 0);
        checks++;
        if (bus.ap_start !== 1'b1) begin
            errors++;
            $display("FAIL ap_start_at_ready: ap_start=%b, required 1", bus.ap_start);
        end
        hi_cycles++;
        commit();
        if (done_dly < 0) return;
        if (done_dly > 0) begin
            for (int i = 1; i < done_dly; i++) begin
                drive(0, 0);
                checks++;
                if (bus.ap_start !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_done: ap_start=%b busy=%b, required 0/1", bus.ap_start, busy);
                end
                commit();
            end
            drive(0, 1);
            commit();
        end
        runs++;
        checks++;
        if (cnt !== CW'(sat(runs, CW)) || cnt2 !== CW2'(sat(runs, CW2))) begin
            errors++;
            $display("FAIL tokens_served: got %0d/%0d, required %0d/%0d",
                     cnt, cnt2, sat(runs, CW), sat(runs, CW2));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fifo_q.delete();
        pending.delete();
        drive(0, 0);
        commit();
        commit();
        reset_n = 1'b1;
        runs = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fifo_q.push_back(8'hA5);
        drive(0, 0);
        checks++;
        if (bus.if_read !== 1'b0 || bus.ap_start !== 1'b0 || busy !== 1'b0 ||
            cnt !== '0 || cnt2 !== '0 || token_data !== '0) begin
            errors++;
            $display("FAIL reset_state: if_read=%b ap_start=%b busy=%b cnt=%0d tok=%h, required all 0",
                     bus.if_read, bus.ap_start, busy, cnt, token_data);
        end
        fifo_q.delete();
        drive(0, 0);
        commit();
        reset_n = 1'b1;
        runs = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0);
            checks++;
            if (bus.if_read !== 1'b0 || bus.ap_start !== 1'b0 || busy !== 1'b0 ||
                cnt !== '0 || bus.if_read_ce !== 1'b1) begin
                errors++;
                $display("FAIL empty_idle: if_read=%b ap_start=%b busy=%b cnt=%0d ce=%b, required 0/0/0/0/1",
                         bus.if_read, bus.ap_start, busy, cnt, bus.if_read_ce);
            end
            commit();
        end
    endtask

    task automatic test_single_run();
        int hi;
        reads = 0;
        push(8'h01);
        serve_run(3, 5, hi);
        checks++;
        if (hi !== 4) begin
            errors++;
            $display("FAIL start_high_cycles: got %0d, required 4", hi);
        end
        checks++;
        if (reads !== 1) begin
            errors++;
            $display("FAIL read_pulses: got %0d, required 1", reads);
        end
        drive(0, 0);
        checks++;
        if (busy !== 1'b0 || bus.ap_start !== 1'b0 || token_data !== 8'h01) begin
            errors++;
            $display("FAIL back_to_idle: busy=%b ap_start=%b tok=%h, required 0/0/01", busy, bus.ap_start, token_data);
        end
        commit();
    endtask

    task automatic test_same_cycle();
        int hi;
        push(DW'($urandom));
        serve_run($urandom_range(0, 2), 0, hi);
        drive(0, 0);
        checks++;
        if (busy !== 1'b0 || bus.ap_start !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_idle: busy=%b ap_start=%b, required 0/0", busy, bus.ap_start);
        end
        commit();
    endtask

    task automatic test_stray_done();
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'b1);
            commit();
            checks++;
            if (cnt !== CW'(sat(runs, CW)) || busy !== 1'b0) begin
                errors++;
                $display("FAIL stray_done: cnt=%0d busy=%b, required %0d/0", cnt, busy, sat(runs, CW));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int hi;
        logic [DW-1:0] t2;
        push(DW'($urandom));
        serve_run(1, -1, hi);
        drive(0, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL in_wait_done: busy=%b, required 1", busy);
        end
        #2;
        reset_n = 1'b0;
        t2 = DW'($urandom);
        push(t2);
        drive(0, 0);
        checks++;
        if (bus.ap_start !== 1'b0 || busy !== 1'b0 || cnt !== '0 || cnt2 !== '0 || bus.if_read !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ap_start=%b busy=%b cnt=%0d/%0d if_read=%b, required all 0",
                     bus.ap_start, busy, cnt, cnt2, bus.if_read);
        end
        commit();
        reset_n = 1'b1;
        runs = 0;
        serve_run(0, 2, hi);
    endtask

    task automatic test_saturation();
        int hi;
        int seq[5] = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(DW'($urandom));
            serve_run($urandom_range(0, 2), $urandom_range(0, 3), hi);
            checks++;
            if (cnt2 !== CW2'(seq[i])) begin
                errors++;
                $display("FAIL saturate_seq[%0d]: got %0d, required %0d", i, cnt2, seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hi;
        int exp_reads;
        logic exp_early;
        do_reset();
        reads = 0;
        push(DW'($urandom));
        push(DW'($urandom));
        serve_run(1, 2, hi);
`ifdef KCORE_START_TOKEN_PREFETCH_EN
        exp_reads = 2;
        exp_early = 1'b1;
`else
        exp_reads = 1;
        exp_early = 1'b0;
`endif
        checks++;
        if (reads !== exp_reads) begin
            errors++;
            $display("FAIL reads_before_done: got %0d, required %0d", reads, exp_reads);
        end
        drive(0, 0);
        checks++;
        if (bus.ap_start !== exp_early) begin
            errors++;
            $display("FAIL second_start_latency: ap_start=%b, required %b", bus.ap_start, exp_early);
        end
`ifndef KCORE_START_TOKEN_PREFETCH_EN
        commit();
        drive(0, 0);
        checks++;
        if (bus.ap_start !== 1'b1) begin
            errors++;
            $display("FAIL second_start_via_idle: ap_start=%b, required 1", bus.ap_start);
        end
`endif
        serve_run(0, 1, hi);
    endtask

    task automatic test_random();
        int hi;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            if (pending.size() == 0 || $urandom_range(0, 2) == 0) begin
                push(DW'($urandom));
                if ($urandom_range(0, 1) == 1) push(DW'($urandom));
            end
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                drive(0, 0);
                commit();
            end
            serve_run($urandom_range(0, 3), $urandom_range(0, 4), hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        bus.if_empty_n = 1'b0;
        bus.if_dout    = '0;
        bus.ap_ready   = 1'b0;
        bus.ap_done    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_run();
        test_same_cycle();
        test_stray_done();
        test_reset_mid_run();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_kcore_start_token_reader.md
KERNEL_KCORE_START_TOKEN_READER -- requirements
Module: kernel_kcore_start_token_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 1: width of the start token carried by the upstream start FIFO.
REQ-002 Parameter CNT_WIDTH, default 16: width of the served-token counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 if_empty_n  input  1  start FIFO holds at least one token.
REQ-007 if_read  output  1  pops one token from the start FIFO this cycle.
REQ-008 if_read_ce  output  1  read clock-enable to the FIFO; tied high.
REQ-009 if_dout  input  DATA_WIDTH  token at the FIFO head.
REQ-010 ap_start  output  1  start request to the downstream process.
REQ-011 ap_ready  input  1  downstream accepted the start; one-cycle pulse.
REQ-012 ap_done  input  1  downstream finished one run; one-cycle pulse.
REQ-013 token_data  output  DATA_WIDTH  token of the run in progress.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 tokens_served  output  CNT_WIDTH  count of completed runs.

Function
REQ-016 FSM states SHALL be IDLE, START and WAIT_DONE.
REQ-017 if_read SHALL equal (state==IDLE && if_empty_n), combinationally; it is never asserted while if_empty_n is 0.
REQ-018 IDLE with if_empty_n=1: capture if_dout into token_data, move to START; ap_start rises on the next cycle (one cycle of latency from token visible to ap_start).
REQ-019 START: ap_start=1 and held until ap_ready=1; ap_start SHALL NOT drop before ap_ready is seen.
REQ-020 START with ap_ready=1 and ap_done=0 -> WAIT_DONE.
REQ-021 START with ap_ready=1 and ap_done=1 in the same cycle -> run complete: increment tokens_served and go to IDLE.
REQ-022 WAIT_DONE with ap_done=1 -> increment tokens_served and go to IDLE.
REQ-023 ap_done outside START/WAIT_DONE SHALL be ignored and SHALL NOT change the counter.
REQ-024 tokens_served SHALL saturate at all-ones and never wrap.
REQ-025 token_data SHALL hold its value until the next capture.

Reset
REQ-026 On reset_n=0, immediately and independent of clk: state=IDLE, ap_start=0, busy=0, token_data=0, tokens_served=0, prefetch slot empty.
REQ-027 Reset mid-run SHALL discard the token in flight; after release, the block resumes from IDLE with the next FIFO token.
REQ-028 if_read SHALL be 0 while reset_n=0.

Configuration
REQ-029 Macro KCORE_START_TOKEN_PREFETCH_EN SHALL, when defined, add a one-entry prefetch slot.
- In WAIT_DONE with the slot empty and if_empty_n=1: assert if_read and store if_dout in the slot.
- On ap_done with the slot full: load token_data from the slot and go directly to START; ap_start is high on the next cycle.
REQ-030 Without KCORE_START_TOKEN_PREFETCH_EN, no slot exists and if_read is asserted only in IDLE, per REQ-017.

Verification
REQ-031 Reset; FIFO empty for 10 cycles -> if_read=0, ap_start=0, busy=0, tokens_served=0.
REQ-032 One token 1; ap_ready 3 cycles after ap_start; ap_done 5 cycles later -> exactly one if_read pulse, token_data=1, ap_start high for 4 cycles, tokens_served=1, back in IDLE.
REQ-033 ap_ready and ap_done in the same cycle -> tokens_served increments by 1, IDLE next cycle, no WAIT_DONE visit.
REQ-034 Reset asserted while in WAIT_DONE -> ap_start=0 and tokens_served=0 asynchronously; after release, the next token is popped normally.
REQ-035 CNT_WIDTH=2 with 5 runs -> tokens_served sequence 1, 2, 3, 3, 3.
REQ-036 Prefetch macro defined; 2 tokens queued -> second if_read occurs during WAIT_DONE; ap_start is high the cycle after the first ap_done; without the macro, the second ap_start is one cycle later, via IDLE.
